// File: rtl/rotate_amount_finder.sv
// Recovers the right-rotation amount k such that rotr(a,k)==y by testing one candidate per clock.
// Latency: done pulses k+2 cycles after the start cycle on a match, WIDTH+1 cycles when none exists.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped, caller must wait.
module rotate_amount_finder #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [AW-1:0]    amt_r,
    output logic [AW-1:0]    amt_l,
    output logic             dir
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last candidate amount; the search stops here so cnt never wraps.
    localparam logic [AW-1:0] CNT_MAX = AW'(WIDTH - 1);
    // Half-turn threshold, one bit wider so WIDTH/2 is representable for any legal WIDTH.
    localparam logic [AW:0]   HALF    = (AW + 1)'(WIDTH / 2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rot_q, rot_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             found_q, found_d;
    logic [AW-1:0]    amt_r_q, amt_r_d;
    logic [AW-1:0]    amt_l_q, amt_l_d;
    logic             dir_q, dir_d;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rot_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            amt_r_q <= '0;
            amt_l_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            amt_r_q <= amt_r_d;
            amt_l_q <= amt_l_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state logic: capture on start, compare/rotate once per cycle, then pulse done.
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        amt_r_d = amt_r_q;
        amt_l_d = amt_l_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rot_d   = a;
                    y_d     = y;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    amt_r_d = '0;
                    amt_l_d = '0;
                    dir_d   = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (rot_q == y_q) begin
                    // First hit is the smallest k because candidates are tried in increasing order.
                    found_d = 1'b1;
                    amt_r_d = cnt_q;
                    amt_l_d = AW'(0) - cnt_q;
                    dir_d   = ({1'b0, cnt_q} <= HALF);
                    state_d = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    found_d = 1'b0;
                    amt_r_d = '0;
                    amt_l_d = '0;
                    dir_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    rot_d = {rot_q[0], rot_q[WIDTH-1:1]};
                    cnt_d = cnt_q + AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign found = found_q;
    assign amt_r = amt_r_q;
    assign amt_l = amt_l_q;
    assign dir   = dir_q;

endmodule

// File: tb/tb_rotate_amount_finder.sv
// Self-checking bench for rotate_amount_finder: directed cases plus randomized vectors.
// Reference model searches all rotations with plain shifts on a doubled word.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_rotate_amount_finder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic        found;
    logic [4:0]  amt_r;
    logic [4:0]  amt_l;
    logic        dir;

    int n_checks = 0;
    int n_errors = 0;

    rotate_amount_finder #(.WIDTH(32), .AW(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .found   (found),
        .amt_r   (amt_r),
        .amt_l   (amt_l),
        .dir     (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Right rotation by k: low half of the doubled word shifted right.
    function automatic logic [31:0] ref_rotr(input logic [31:0] x, input int k);
        logic [63:0] d;
        d = {x, x} >> k;
        return d[31:0];
    endfunction

    // Smallest k in 0..31 with ref_rotr(x,k)==t, or -1 when none.
    function automatic int ref_find(input logic [31:0] x, input logic [31:0] t);
        for (int k = 0; k < 32; k++) begin
            if (ref_rotr(x, k) == t) return k;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits from cycle 1 onward until done is seen or the bound expires.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic chk_result(input string tag, input int k, input int cyc);
        int exp_lat;
        exp_lat = (k < 0) ? 33 : k + 2;
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        if (k < 0) begin
            chk({tag, "_found"}, {31'b0, found}, 32'd0);
            chk({tag, "_amt_r"}, {27'b0, amt_r}, 32'd0);
            chk({tag, "_amt_l"}, {27'b0, amt_l}, 32'd0);
            chk({tag, "_dir"}, {31'b0, dir}, 32'd0);
        end else begin
            chk({tag, "_found"}, {31'b0, found}, 32'd1);
            chk({tag, "_amt_r"}, {27'b0, amt_r}, k);
            chk({tag, "_amt_l"}, {27'b0, amt_l}, (32 - k) % 32);
            chk({tag, "_dir"}, {31'b0, dir}, (k <= 16) ? 32'd1 : 32'd0);
        end
    endtask

    // One complete search from a start pulse; returns at the IDLE cycle after done.
    task automatic do_search(input logic [31:0] av, input logic [31:0] yv, input string tag);
        int k;
        int cyc;
        k = ref_find(av, yv);
        start = 1'b1;
        a = av;
        y = yv;
        step();
        start = 1'b0;
        a = $urandom;
        y = $urandom;
        chk({tag, "_clr"}, {31'b0, found}, 32'd0);
        wait_done(cyc);
        chk_result(tag, k, cyc);
        step();
        chk({tag, "_pulse"}, {30'b0, done, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        int k;
        logic [31:0] av;
        logic [31:0] yv;
        logic [31:0] a1, y1, a2, y2;

        reset_n = 1'b0;
        start = 1'b0;
        a = '0;
        y = '0;
        repeat (3) step();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_found", {31'b0, found}, 32'd0);
        chk("rst_amt", {22'b0, amt_r, amt_l}, 32'd0);
        chk("rst_dir", {31'b0, dir}, 32'd0);
        reset_n = 1'b1;
        step();

        do_search(32'h0000_0001, 32'h8000_0000, "t_k1");
        do_search(32'h1234_5678, 32'h2345_6781, "t_rotl4");
        do_search(32'h0000_FFFF, 32'hFFFF_0000, "t_half");
        do_search(32'hAAAA_AAAA, 32'hAAAA_AAAA, "t_same");
        do_search(32'h0000_0001, 32'h0000_0003, "t_nomatch");
        do_search(32'h0000_0000, 32'h0000_0000, "t_zero");
        do_search(32'hFFFF_FFFF, 32'hFFFF_FFFF, "t_ones");

        // Reset in cycle 10 of a k=20 search.
        start = 1'b1;
        a = 32'h1234_5678;
        y = ref_rotr(32'h1234_5678, 20);
        step();
        start = 1'b0;
        repeat (9) step();
        chk("mid_busy_before", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        step();
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk("mid_done", {31'b0, done}, 32'd0);
        chk("mid_outs", {21'b0, found, amt_r, amt_l, dir}, 32'd0);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        chk("mid_no_done", pulses, 0);
        do_search(32'h1234_5678, ref_rotr(32'h1234_5678, 20), "mid_after");

        // start held high across two searches; inputs change while busy.
        a1 = 32'hDEAD_BEEF;
        y1 = ref_rotr(a1, 7);
        a2 = 32'hCAFE_F00D;
        y2 = ref_rotr(a2, 25);
        start = 1'b1;
        a = a1;
        y = y1;
        step();
        a = $urandom;
        y = $urandom;
        wait_done(cyc);
        chk_result("hs_first", 7, cyc);
        a = $urandom;
        y = $urandom;
        step();
        chk("hs_idle", {31'b0, busy}, 32'd0);
        a = a2;
        y = y2;
        step();
        a = $urandom;
        y = $urandom;
        chk("hs_accept", {31'b0, busy}, 32'd1);
        wait_done(cyc);
        chk_result("hs_second", 25, cyc);
        start = 1'b0;
        step();
        chk("hs_end", {30'b0, done, busy}, 32'd0);

        // Randomized vectors: rotated words, periodic words, and unrelated pairs.
        for (int n = 0; n < 1000; n++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                av = $urandom;
                yv = $urandom;
            end else if (k == 1) begin
                av = {8{4'($urandom_range(0, 15))}};
                yv = ref_rotr(av, $urandom_range(0, 31));
            end else begin
                av = $urandom;
                yv = ref_rotr(av, $urandom_range(0, 31));
            end
            do_search(av, yv, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rotate_amount_finder.md
Name: rotate_amount_finder

Overview:
- Iterative inverse of the 32-bit multifunction barrel shifter. Takes an original word and a rotated word, and recovers the rotation amount (and direction) that maps one to the other.
- Used to check and decode rotator results and to recover alignment offsets.
- Searches one candidate rotation per clock under a start/done handshake, with a shift register and a counter.
- Reports the smallest right-rotation amount, its equivalent left amount, and whether any rotation matches.

Parameters:
- WIDTH, 32, data width; must be a power of two ≥ 2.
- AW, 5, amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  original (unrotated) word; captured when start is accepted.
- y  input  WIDTH  rotated word to decode; captured when start is accepted.
- busy  output  1  high in SEARCH and DONE.
- done  output  1  one-cycle pulse when a result is valid.
- found  output  1  a rotation of a equals y.
- amt_r  output  AW  smallest k with rotr(a,k)==y.
- amt_l  output  AW  equivalent left-rotation amount, (WIDTH−k) mod WIDTH.
- dir  output  1  shortest direction: 1 = right (k ≤ WIDTH/2), 0 = left.

Behaviour:
- **Reset.** reset_n low at a rising edge forces state=IDLE and clears busy, done, found, amt_r, amt_l, dir and the internal registers to 0. This applies from any state, including mid-search: the search is abandoned and no done pulse is produced.
- **Rotation definition.** rotr(x,1) = {x[0], x[WIDTH−1:1]}, the same bit order as the barrel shifter's right rotation (dir=1).
- **State IDLE.**
  - busy=0.
  - If start=1: capture a into rot_reg and y into y_reg, set cnt=0, go to SEARCH.
  - Result outputs keep their previous values until the start is accepted, then are cleared to 0 on that edge.
- **State SEARCH**, one comparison per cycle:
  - If rot_reg==y_reg: amt_r←cnt, amt_l←(0−cnt) mod WIDTH, found←1, dir←(cnt ≤ WIDTH/2), go to DONE.
  - Else if cnt==WIDTH−1: found←0, amt_r←0, amt_l←0, dir←0, go to DONE.
  - Else: rot_reg←rotr(rot_reg,1), cnt←cnt+1.
- **State DONE.** done=1 for exactly one cycle, then IDLE. Results hold until the next accepted start.
- **Latency.**
  - Count start-high cycle as cycle 0.
  - Match at k: done is high in cycle k+2.
  - No match: done is high in cycle WIDTH+1 (33 for the default).
  - Back-to-back: the earliest next start is accepted in the cycle after done.
- **start while busy** (SEARCH or DONE) is ignored. Changes on a and y after capture have no effect.
- **Multiple matches** (periodic words, e.g. all-zero, all-ones, 0xAAAAAAAA): the smallest k is reported. For a==y this is always k=0, amt_l=0, dir=1.
- **k = WIDTH/2:** dir=1. For k=0: amt_l=0.
- **Width rules.** cnt is AW bits and never wraps: the loop exits at WIDTH−1. amt_l is computed in AW-bit two's-complement arithmetic.
- **Single clock domain.** No combinational path from inputs to outputs.

Test Plan:
- a=0x00000001, y=0x80000000, start pulse → done in cycle 3; found=1, amt_r=1, amt_l=31, dir=1.
- a=0x12345678, y=0x23456781 (rotl 4) → done in cycle 30; found=1, amt_r=28, amt_l=4, dir=0.
- a=0x0000FFFF, y=0xFFFF0000 → found=1, amt_r=16, amt_l=16, dir=1 (tie goes right). Then a=y=0xAAAAAAAA → amt_r=0, amt_l=0, done in cycle 2.
- a=0x00000001, y=0x00000003 → done in cycle 33; found=0, amt_r=0, amt_l=0, dir=0.
- Reset mid-operation:
  - Start a search with k=20; drive reset_n=0 in cycle 10 → next edge: IDLE, busy=0, all outputs 0, no done pulse.
  - Then a new start → correct result.
- Handshake:
  - Assert start continuously across two searches, changing a and y mid-search → second search uses the values present in the cycle after done.
  - Random self-check: compare against rotating the shifter's output by random amounts for 1000 vectors.
